// File: rtl/rtc_bus_scheduler_pkg.sv
// rtc_bus_scheduler_pkg
// Shared definitions for the RTC bus scheduler:
//   - scheduler FSM state enumeration
//   - RTC register addresses and command addresses
//   - command bytes issued at the start/end of a sequence
//   - write-group codes
//   - local-bank index -> RTC address lookup
package rtc_bus_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Time-of-day registers
  localparam logic [7:0] ADDR_SEG       = 8'h21;
  localparam logic [7:0] ADDR_MIN       = 8'h22;
  localparam logic [7:0] ADDR_HORA      = 8'h23;
  // Date registers
  localparam logic [7:0] ADDR_DIA       = 8'h24;
  localparam logic [7:0] ADDR_MES       = 8'h25;
  localparam logic [7:0] ADDR_ANIO      = 8'h26;
  localparam logic [7:0] ADDR_DIA_SEM   = 8'h27;
  // Timer registers
  localparam logic [7:0] ADDR_TMR_SEG   = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN   = 8'h42;
  localparam logic [7:0] ADDR_TMR_HORA  = 8'h43;
  // Command addresses
  localparam logic [7:0] ADDR_CMD_REF   = 8'hF0;
  localparam logic [7:0] ADDR_CMD_WR    = 8'hF1;

  // Command bytes
  localparam logic [7:0] CMD_REFRESH    = 8'hF0;
  localparam logic [7:0] CMD_WR_COMMIT  = 8'hD2;

  // Write-group codes
  localparam logic [1:0] GRP_HORA       = 2'd0;
  localparam logic [1:0] GRP_FECHA      = 2'd1;
  localparam logic [1:0] GRP_TIMER      = 2'd2;
  localparam logic [1:0] GRP_RSVD       = 2'd3;

  // addr_local value while a command cycle is on the bus
  localparam logic [3:0] IDX_NONE       = 4'hF;

  function automatic logic [7:0] idx_to_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = ADDR_SEG;
      4'd1:    a = ADDR_MIN;
      4'd2:    a = ADDR_HORA;
      4'd3:    a = ADDR_DIA;
      4'd4:    a = ADDR_MES;
      4'd5:    a = ADDR_ANIO;
      4'd6:    a = ADDR_DIA_SEM;
      4'd7:    a = ADDR_TMR_SEG;
      4'd8:    a = ADDR_TMR_MIN;
      4'd9:    a = ADDR_TMR_HORA;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_seq_rom.sv
// rtc_seq_rom
// Combinational description of every bus cycle in a sequence.
//   i_seq_wr    : 1 = write-group sequence, 0 = refresh sequence
//   i_group     : write group (ignored for refresh)
//   i_step      : cycle number within the sequence, from 0
//   o_addr      : RTC address for the cycle
//   o_w_r       : 1 = write, 0 = read
//   o_cmd       : 1 = command cycle (data from o_cmd_data)
//   o_cmd_data  : command byte, 0x00 for register cycles
//   o_index     : local bank index, 0xF for command cycles
//   o_last      : this step is the final cycle of the sequence
module rtc_seq_rom
  import rtc_bus_scheduler_pkg::*;
(
  input  logic       i_seq_wr,
  input  logic [1:0] i_group,
  input  logic [3:0] i_step,
  output logic [7:0] o_addr,
  output logic       o_w_r,
  output logic       o_cmd,
  output logic [7:0] o_cmd_data,
  output logic [3:0] o_index,
  output logic       o_last
);

  logic [3:0] w_base;
  logic [3:0] w_count;
  logic [3:0] w_idx;

  always_comb begin
    o_addr     = 8'h00;
    o_w_r      = 1'b0;
    o_cmd      = 1'b0;
    o_cmd_data = 8'h00;
    o_index    = IDX_NONE;
    o_last     = 1'b0;
    w_base     = 4'd0;
    w_count    = 4'd0;
    w_idx      = 4'd0;

    if (!i_seq_wr) begin
      // Refresh: latch command first, then read the whole bank 0..9
      if (i_step == 4'd0) begin
        o_addr     = ADDR_CMD_REF;
        o_w_r      = 1'b1;
        o_cmd      = 1'b1;
        o_cmd_data = CMD_REFRESH;
      end else begin
        w_idx   = i_step - 4'd1;
        o_index = w_idx;
        o_addr  = idx_to_addr(w_idx);
        o_last  = (i_step == 4'd10);
      end
    end else begin
      case (i_group)
        GRP_HORA:  begin w_base = 4'd0; w_count = 4'd3; end
        GRP_FECHA: begin w_base = 4'd3; w_count = 4'd4; end
        GRP_TIMER: begin w_base = 4'd7; w_count = 4'd3; end
        default:   begin w_base = 4'd0; w_count = 4'd0; end
      endcase
      o_w_r = 1'b1;
      // Register writes ascending, then the commit command closes the group
      if (i_step < w_count) begin
        w_idx   = w_base + i_step;
        o_index = w_idx;
        o_addr  = idx_to_addr(w_idx);
      end else begin
        o_addr     = ADDR_CMD_WR;
        o_cmd      = 1'b1;
        o_cmd_data = CMD_WR_COMMIT;
        o_last     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
// Sequences RTC bus cycles for bank refreshes and configuration-group writes.
//   clk, reset     : clock, synchronous active-low reset
//   refresh_tick   : request full read refresh (merged one-deep while busy)
//   wr_req/wr_group: request write of a group (group 3 ignored)
//   cyc_done       : completion pulse from the bus-cycle generator
//   cyc_start      : launches one bus cycle
//   cyc_w_r, cyc_addr, cyc_cmd, cmd_data, addr_local : cycle descriptor
//   wr_ack, refresh_done, err : sequence completion / abort pulses
//   busy           : scheduler not idle
module rtc_bus_scheduler
  import rtc_bus_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       wr_req,
  input  logic [1:0] wr_group,
  input  logic       cyc_done,
  output logic       cyc_start,
  output logic       cyc_w_r,
  output logic [7:0] cyc_addr,
  output logic       cyc_cmd,
  output logic [7:0] cmd_data,
  output logic [3:0] addr_local,
  output logic       wr_ack,
  output logic       refresh_done,
  output logic       err,
  output logic       busy
);

  state_t     r_state;
  state_t     w_state_next;

  logic       r_seq_wr;
  logic [1:0] r_group;
  logic [3:0] r_step;
  logic       r_last;
  logic [7:0] r_wait_cnt;
  logic       r_refresh_pending;

  logic       r_cyc_w_r;
  logic [7:0] r_cyc_addr;
  logic       r_cyc_cmd;
  logic [7:0] r_cmd_data;
  logic [3:0] r_addr_local;

  logic       w_wr_accept;
  logic       w_ref_accept;
  logic       w_timeout;
  logic       w_load;

  logic       w_rom_wr;
  logic [1:0] w_rom_group;
  logic [3:0] w_rom_step;
  logic [7:0] w_rom_addr;
  logic       w_rom_w_r;
  logic       w_rom_cmd;
  logic [7:0] w_rom_cmd_data;
  logic [3:0] w_rom_index;
  logic       w_rom_last;

  // A write always wins over a refresh in IDLE
  assign w_wr_accept  = (r_state == ST_IDLE) && wr_req && (wr_group != GRP_RSVD);
  assign w_ref_accept = (r_state == ST_IDLE) && !w_wr_accept &&
                        (refresh_tick || r_refresh_pending);
  // A cyc_done arriving on the final count still completes the cycle
  assign w_timeout    = (r_state == ST_WAIT) && !cyc_done &&
                        (r_wait_cnt == 8'(TIMEOUT_CYC));
  assign w_load       = w_wr_accept || w_ref_accept ||
                        ((r_state == ST_NEXT) && !r_last);

  // ROM is addressed with the step about to be issued so the descriptor
  // can be registered on entry to ISSUE
  assign w_rom_wr    = (r_state == ST_IDLE) ? w_wr_accept : r_seq_wr;
  assign w_rom_group = (r_state == ST_IDLE) ? wr_group : r_group;
  assign w_rom_step  = (r_state == ST_IDLE) ? 4'd0 : (r_step + 4'd1);

  rtc_seq_rom u_rom (
    .i_seq_wr   (w_rom_wr),
    .i_group    (w_rom_group),
    .i_step     (w_rom_step),
    .o_addr     (w_rom_addr),
    .o_w_r      (w_rom_w_r),
    .o_cmd      (w_rom_cmd),
    .o_cmd_data (w_rom_cmd_data),
    .o_index    (w_rom_index),
    .o_last     (w_rom_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_wr_accept || w_ref_accept) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (cyc_done)       w_state_next = ST_NEXT;
        else if (w_timeout) w_state_next = ST_IDLE;
      end
      ST_NEXT:  w_state_next = r_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seq_wr          <= 1'b0;
      r_group           <= 2'd0;
      r_step            <= 4'd0;
      r_last            <= 1'b0;
      r_wait_cnt        <= 8'd0;
      r_refresh_pending <= 1'b0;
      r_cyc_w_r         <= 1'b0;
      r_cyc_addr        <= 8'h00;
      r_cyc_cmd         <= 1'b0;
      r_cmd_data        <= 8'h00;
      r_addr_local      <= IDX_NONE;
    end else begin
      if (w_load) begin
        r_seq_wr     <= w_rom_wr;
        r_group      <= w_rom_group;
        r_step       <= w_rom_step;
        r_last       <= w_rom_last;
        r_cyc_w_r    <= w_rom_w_r;
        r_cyc_addr   <= w_rom_addr;
        r_cyc_cmd    <= w_rom_cmd;
        r_cmd_data   <= w_rom_cmd_data;
        r_addr_local <= w_rom_index;
      end

      if (r_state == ST_ISSUE)
        r_wait_cnt <= 8'd0;
      else if ((r_state == ST_WAIT) && (r_wait_cnt != 8'hFF))
        r_wait_cnt <= r_wait_cnt + 8'd1;

      // Ticks that cannot be taken right now merge into one pending refresh
      if (w_ref_accept)      r_refresh_pending <= 1'b0;
      else if (refresh_tick) r_refresh_pending <= 1'b1;
    end
  end

  assign cyc_start    = (r_state == ST_ISSUE);
  assign busy         = (r_state != ST_IDLE);
  assign wr_ack       = (r_state == ST_DONE) && r_seq_wr;
  assign refresh_done = (r_state == ST_DONE) && !r_seq_wr;
  assign err          = w_timeout;
  assign cyc_w_r      = r_cyc_w_r;
  assign cyc_addr     = r_cyc_addr;
  assign cyc_cmd      = r_cyc_cmd;
  assign cmd_data     = r_cmd_data;
  assign addr_local   = r_addr_local;

endmodule
